// File: rtl/jt51_lfo_pkg.sv
// Shared definitions for the JT51 LFO: waveform codes, LFSR seed/taps and the
// waveform shaper that turns the phase or noise byte into raw AM/PM values.
package jt51_lfo_pkg;

  typedef enum logic [1:0] {
    LFO_SAW = 2'd0,
    LFO_SQR = 2'd1,
    LFO_TRI = 2'd2,
    LFO_NOI = 2'd3
  } lfo_wave_e;

  localparam logic [14:0] LFO_SEED    = 15'h7FFF;
  localparam int          LFSR_TAP_HI = 14;  // x^15
  localparam int          LFSR_TAP_LO = 13;  // x^14

  typedef struct packed {
    logic [7:0] am;    // unsigned AM attenuation before depth scaling
    logic       sign;  // PM direction, 1 = subtract
    logic [6:0] mag;   // PM magnitude before depth scaling
  } lfo_raw_t;

  function automatic lfo_raw_t lfo_shape(input logic [1:0] w,
                                         input logic [7:0] ph,
                                         input logic [7:0] nb);
    lfo_raw_t r;
    r = '0;
    case (lfo_wave_e'(w))
      LFO_SAW: begin
        r.am   = ~ph;
        r.sign = ph[7];
        r.mag  = ph[6:0];
      end
      LFO_SQR: begin
        r.am   = ph[7] ? 8'h00 : 8'hFF;
        r.sign = ph[7];
        r.mag  = 7'h7F;
      end
      LFO_TRI: begin
        // 255-2x and 127-2k are plain inversions of the doubled value
        r.am   = ph[7] ? {ph[6:0], 1'b1} : ~{ph[6:0], 1'b0};
        r.sign = ph[7];
        r.mag  = ph[6] ? ~{ph[5:0], 1'b0} : {ph[5:0], 1'b0};
      end
      LFO_NOI: begin
        r.am   = nb;
        r.sign = nb[7];
        r.mag  = nb[6:0];
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jt51_lfo_mul.sv
// Serial shift-add multiplier: one multiplier bit per cen cycle, result
// (a*b)>>BW is valid on the cycle o_done is high. A new start restarts it.
module jt51_lfo_mul #(
  parameter int AW = 8,
  parameter int BW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cen,
  input  logic          i_start,
  input  logic [AW-1:0] i_a,
  input  logic [BW-1:0] i_b,
  output logic          o_done,
  output logic [AW-1:0] o_prod
);

  localparam int PW = AW + BW;
  localparam int CW = $clog2(BW + 1);

  logic [PW-1:0] r_a;
  logic [BW-1:0] r_b;
  logic [PW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_cen) begin
      if (i_start) begin
        r_a    <= PW'(i_a);
        r_b    <= i_b;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_cnt == CW'(BW)) begin
          r_busy <= 1'b0;
        end else begin
          if (r_b[0]) r_acc <= r_acc + r_a;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_done = i_cen & r_busy & ~i_start & (r_cnt == CW'(BW));
  assign o_prod = r_acc[PW-1:BW];

endmodule

// File: rtl/jt51_lfo_unit.sv
// JT51 LFO: exponent/mantissa rate divider, 8-bit phase, 15-bit noise LFSR and
// waveform shaping, with depth scaling by two serial multipliers.
module jt51_lfo_unit
  import jt51_lfo_pkg::*;
#(
  parameter logic [14:0] SEED = LFO_SEED,
  parameter int          DIVW = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cen,
  input  logic       i_zero,
  input  logic       i_lfo_rst,
  input  logic [7:0] i_lfo_freq,
  input  logic [1:0] i_lfo_w,
  input  logic [6:0] i_lfo_amd,
  input  logic [6:0] i_lfo_pmd,
  output logic [7:0] o_am,
  output logic [7:0] o_pm
);

  logic [4:0]      r_frac;
  logic [DIVW-1:0] r_div;
  logic [7:0]      r_ph;
  logic [7:0]      r_nb;
  logic [14:0]     r_lfsr;
  logic            r_sign;
  logic [7:0]      r_am;
  logic [7:0]      r_pm;

  logic            w_s;
  logic [3:0]      w_e;
  logic [5:0]      w_sum;
  logic            w_carry;
  logic [DIVW-1:0] w_mask;
  logic            w_step;
  logic            w_fb;
  lfo_raw_t        w_raw;
  logic            w_am_done;
  logic            w_pm_done;
  logic [7:0]      w_am_prod;
  logic [6:0]      w_pmag;

  assign w_s     = i_cen & i_zero;
  assign w_e     = i_lfo_freq[7:4];
  assign w_sum   = {1'b0, r_frac} + {2'b01, i_lfo_freq[3:0]};
  assign w_carry = w_sum[5];

  // NOTE: every always_comb output gets a value on every path (here by the
  // full loop) so no latch can be inferred.
  always_comb begin
    for (int j = 0; j < DIVW; j++) w_mask[j] = (j < DIVW - int'(w_e));
  end

  // Step once the low (DIVW-e) divider bits are all ones; e=15 leaves no bits
  assign w_step = w_carry & ((r_div & w_mask) == w_mask) & ~i_lfo_rst;
  assign w_fb   = r_lfsr[LFSR_TAP_HI] ^ r_lfsr[LFSR_TAP_LO];
  assign w_raw  = lfo_shape(i_lfo_w, r_ph, r_nb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frac <= '0;
      r_div  <= '0;
      r_ph   <= '0;
      r_nb   <= '0;
      r_lfsr <= SEED;
      r_sign <= 1'b0;
    end else if (w_s) begin
      r_lfsr <= {r_lfsr[13:0], w_fb};
      r_sign <= w_raw.sign;
      if (i_lfo_rst) begin
        r_frac <= '0;
        r_div  <= '0;
        r_ph   <= '0;
      end else begin
        r_frac <= w_sum[4:0];
        if (w_carry) r_div <= r_div + 1'b1;
        if (w_step) begin
          r_ph <= r_ph + 1'b1;
          r_nb <= r_lfsr[7:0];
        end
      end
    end
  end

  jt51_lfo_mul #(.AW(8), .BW(7)) u_am_mul (
    .clk     (clk),
    .rst     (rst),
    .i_cen   (i_cen),
    .i_start (w_s),
    .i_a     (w_raw.am),
    .i_b     (i_lfo_amd),
    .o_done  (w_am_done),
    .o_prod  (w_am_prod)
  );

  jt51_lfo_mul #(.AW(7), .BW(7)) u_pm_mul (
    .clk     (clk),
    .rst     (rst),
    .i_cen   (i_cen),
    .i_start (w_s),
    .i_a     (w_raw.mag),
    .i_b     (i_lfo_pmd),
    .o_done  (w_pm_done),
    .o_prod  (w_pmag)
  );

  // Outputs move only when a multiply finishes; a zero magnitude drops the sign
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_am <= '0;
      r_pm <= '0;
    end else begin
      if (w_am_done) r_am <= w_am_prod;
      if (w_pm_done) r_pm <= {r_sign & (|w_pmag), w_pmag};
    end
  end

  assign o_am = r_am;
  assign o_pm = r_pm;

endmodule

// File: tb/tb_jt51_lfo_unit.sv
// Self-checking bench for jt51_lfo_unit: a sample-level reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_jt51_lfo_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cen = 1'b0;
  logic       zero = 1'b0;
  logic       lfo_rst = 1'b0;
  logic [7:0] lfo_freq = 8'h00;
  logic [1:0] lfo_w = 2'd0;
  logic [6:0] lfo_amd = 7'd0;
  logic [6:0] lfo_pmd = 7'd0;
  logic [7:0] am;
  logic [7:0] pm;

  int n_tests = 0;
  int n_fail  = 0;

  jt51_lfo_unit dut (
    .clk        (clk),
    .rst        (rst),
    .i_cen      (cen),
    .i_zero     (zero),
    .i_lfo_rst  (lfo_rst),
    .i_lfo_freq (lfo_freq),
    .i_lfo_w    (lfo_w),
    .i_lfo_amd  (lfo_amd),
    .i_lfo_pmd  (lfo_pmd),
    .o_am       (am),
    .o_pm       (pm)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model (one sample at a time) ----------------
  int m_ph = 0, m_frac = 0, m_div = 0, m_nb = 0, m_lfsr = 32'h7FFF;
  int m_cnt = 0, m_pa = 0, m_pp = 0, m_am = 0, m_pm = 0;

  task automatic model_reset();
    m_ph = 0; m_frac = 0; m_div = 0; m_nb = 0; m_lfsr = 32'h7FFF;
    m_cnt = 0; m_pa = 0; m_pp = 0; m_am = 0; m_pm = 0;
  endtask

  task automatic model_sample();
    int ra, sg, mg, k, pmag, e, period, fb;
    bit step;
    case (int'(lfo_w))
      0: begin ra = 255 - m_ph; mg = m_ph % 128; end
      1: begin ra = (m_ph >= 128) ? 0 : 255; mg = 127; end
      2: begin
        ra = (m_ph >= 128) ? 2 * (m_ph % 128) + 1 : 255 - 2 * (m_ph % 128);
        k  = m_ph % 64;
        mg = ((m_ph % 128) >= 64) ? 127 - 2 * k : 2 * k;
      end
      default: begin ra = m_nb; mg = m_nb % 128; end
    endcase
    sg = (int'(lfo_w) == 3) ? (m_nb >= 128) : (m_ph >= 128);
    m_pa = (ra * int'(lfo_amd)) / 128;
    pmag = (mg * int'(lfo_pmd)) / 128;
    m_pp = (pmag != 0) ? sg * 128 + pmag : 0;
    m_cnt = 8;
    step = 1'b0;
    if (lfo_rst) begin
      m_ph = 0; m_frac = 0; m_div = 0;
    end else begin
      m_frac = m_frac + 16 + int'(lfo_freq[3:0]);
      if (m_frac >= 32) begin
        m_frac -= 32;
        e = int'(lfo_freq[7:4]);
        period = 1 << (15 - e);
        step = ((m_div % period) == period - 1);
        m_div = (m_div + 1) % 32768;
      end
      if (step) begin
        m_nb = m_lfsr % 256;
        m_ph = (m_ph + 1) % 256;
      end
    end
    fb = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
    m_lfsr = ((m_lfsr * 2) % 32768) | fb;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else if (cen) begin
      if (zero) model_sample();
      else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_am = m_pa; m_pm = m_pp; end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    check("cyc_am", int'(am), m_am);
    check("cyc_pm", int'(pm), m_pm);
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] p7_am, p7_pm, p8_am, p8_pm;

  task automatic tick(input bit c, input bit z);
    cen = c;
    zero = z;
    @(posedge clk);
    #2;
  endtask

  // One 32-slot frame; optional lfo_rst change at a slot and cen=0 gaps
  // (with zero held high to show it is ignored without cen).
  task automatic frame(input int rst_slot, input bit rst_val, input bit gaps);
    for (int s = 0; s < 32; s++) begin
      if (s == rst_slot) lfo_rst = rst_val;
      tick(1'b1, s == 0);
      if (s == 7) begin p7_am = am; p7_pm = pm; end
      if (s == 8) begin p8_am = am; p8_pm = pm; end
      if (gaps && (s % 5 == 0)) tick(1'b0, 1'b1);
    end
  endtask

  task automatic steer(input int target, input string name);
    for (int k = 0; k < 400 && m_ph != target; k++) frame(-1, 1'b0, 1'b0);
    if (m_ph != target) timeout_fail(name);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    #1 rst = 1'b1;
    @(posedge clk); #2;
    repeat (3) tick(1'b1, 1'b0);
    check("reset_am", int'(am), 0);
    check("reset_pm", int'(pm), 0);
    rst = 1'b0;

    // Noise from a fresh LFSR: second sample latches nb=FE, third uses it
    lfo_freq = 8'hFF; lfo_w = 2'd3; lfo_amd = 7'd127; lfo_pmd = 7'd127;
    repeat (3) frame(-1, 1'b0, 1'b0);
    check("noise_first_am", int'(am), 252);
    check("noise_first_pm", int'(pm), 8'hFD);
    for (int i = 0; i < 64; i++) frame(-1, 1'b0, (i % 4) == 0);

    // Slowest rate, saw: ph advances every second sample
    lfo_freq = 8'hF0; lfo_w = 2'd0; lfo_amd = 7'd127; lfo_pmd = 7'd0;
    lfo_rst = 1'b1;
    frame(-1, 1'b0, 1'b0);
    lfo_rst = 1'b0;
    for (int n = 0; n <= 512; n++) begin
      frame(-1, 1'b0, 1'b0);
      if (n == 0)   check("saw_ph0_am", int'(am), 253);
      if (n == 2)   check("saw_ph1_am", int'(am), 252);
      if (n == 511) check("saw_ph255_am", int'(am), 0);
      if (n == 512) check("saw_wrap_am", int'(am), 253);
    end

    // Square PM, fastest rate, with the exact 8-cen output latency
    lfo_freq = 8'hFF; lfo_w = 2'd1; lfo_amd = 7'd127; lfo_pmd = 7'd127;
    lfo_rst = 1'b1;
    frame(-1, 1'b0, 1'b0);
    lfo_rst = 1'b0;
    frame(-1, 1'b0, 1'b0);
    check("sqr_pos_pm", int'(pm), 8'h7E);
    steer(128, "steer_sqr");
    frame(-1, 1'b0, 1'b1);
    check("sqr_slot7_pm", int'(p7_pm), 8'h7E);
    check("sqr_slot8_pm", int'(p8_pm), 8'hFE);
    check("sqr_slot7_am", int'(p7_am), 253);
    check("sqr_slot8_am", int'(p8_am), 0);

    // Zero depth: no output and never a negative zero on PM
    lfo_amd = 7'd0; lfo_pmd = 7'd0;
    for (int w = 0; w < 4; w++) begin
      lfo_w = 2'(w);
      frame(-1, 1'b0, 1'b0);
      frame(-1, 1'b0, 1'b1);
      check("zero_depth_am", int'(am), 0);
      check("zero_depth_pm", int'(pm), 0);
    end

    // lfo_rst rises mid-multiply at ph=9A and holds for three samples
    lfo_w = 2'd0; lfo_amd = 7'd127; lfo_pmd = 7'd127;
    steer(8'h9A, "steer_9a");
    frame(3, 1'b1, 1'b0);
    check("inflight_am", int'(am), 100);
    check("inflight_pm", int'(pm), 8'h99);
    frame(-1, 1'b0, 1'b0);
    frame(-1, 1'b0, 1'b0);
    frame(-1, 1'b0, 1'b0);
    check("lforst_am", int'(am), 253);
    check("lforst_pm", int'(pm), 0);
    lfo_rst = 1'b0;
    frame(-1, 1'b0, 1'b0);
    frame(-1, 1'b0, 1'b0);
    check("lforst_frac0_am", int'(am), 253);
    frame(-1, 1'b0, 1'b0);
    check("lforst_step_am", int'(am), 252);

    // Two samples 3 cen apart: the second restarts the multiply and wins
    lfo_w = 2'd1; lfo_amd = 7'd32; lfo_pmd = 7'd0;
    lfo_rst = 1'b1;
    frame(-1, 1'b0, 1'b0);
    lfo_rst = 1'b0;
    frame(-1, 1'b0, 1'b0);
    check("dbl_pre_am", int'(am), 63);
    lfo_amd = 7'd127;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    lfo_amd = 7'd64;
    tick(1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b0);
      if (k == 5) check("dbl_first_dropped", int'(am), 63);
      if (k == 7) check("dbl_before_done", int'(am), 63);
      if (k == 8) check("dbl_second_wins", int'(am), 127);
    end
    repeat (20) tick(1'b1, 1'b0);

    // Asynchronous reset in the middle of a multiply clears at once
    lfo_amd = 7'd127;
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_am", int'(am), 0);
    check("rst_mid_pm", int'(pm), 0);
    repeat (2) tick(1'b1, 1'b0);
    rst = 1'b0;
    repeat (12) tick(1'b1, 1'b0);
    check("rst_hold_am", int'(am), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
